fetch_unit: RTL and testbench

//  Instruction fetch stage directly upstream of the decoder. After reset it reads the 6502 reset vector.
//  It then fetches opcode + 0..2 operand bytes from memory, advances PC and presents one whole instruction
//  (opcode, operands, length, PC) to the decoder over a valid/ready handshake. Holds the architectural PC.

---
 rtl/fetch_unit.sv | 234 +++++++++++++++++++++++
 tb/tb_fetch_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage that sits directly upstream of the 6502 decoder.
//   After reset it reads the reset vector at RESET_VECTOR and RESET_VECTOR+1 and
//   loads the PC from it. It then loops: it fetches an opcode and 0..2 operand
//   bytes, advances the PC, and presents one whole instruction to the decoder.
//   It holds the architectural PC.
//
// Ports
//   clk, reset          single clock; synchronous active-high reset
//   mem_addr, mem_rd    read request, decoded from state and PC (combinational)
//   mem_rdata           read data, valid exactly one cycle after mem_rd
//   pc_load, pc_load_val redirect request; honoured in OPC, B1, B2, B3 and OUT
//   inst_valid, inst_ready bundle handshake (see below)
//   inst_opcode, inst_op1, inst_op2, inst_len, inst_pc  registered bundle
//   pc_out              registered PC (address of the next byte to fetch)
//   dbg_state           current FSM state encoding, for checkers
//
// Handshake: the bundle is transferred on a cycle where inst_valid & inst_ready
//   are both high. While inst_valid is high the bundle stays stable until that
//   transfer, and inst_valid does not drop without a transfer except on a
//   redirect (pc_load) or reset. inst_valid depends only on registered state,
//   never on inst_ready.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned             ADDR_WIDTH   = 16,
  parameter int unsigned             DATA_WIDTH   = 8,
  parameter logic [ADDR_WIDTH-1:0]   RESET_VECTOR = 16'hFFFC
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] pc_load_val,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst_opcode,
  output logic [DATA_WIDTH-1:0] inst_op1,
  output logic [DATA_WIDTH-1:0] inst_op2,
  output logic [1:0]            inst_len,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_VLO  = 3'd0,
    S_VHI  = 3'd1,
    S_VSET = 3'd2,
    S_OPC  = 3'd3,
    S_B1   = 3'd4,
    S_B2   = 3'd5,
    S_B3   = 3'd6,
    S_OUT  = 3'd7
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] vec_lo_q;
  logic                  inst_valid_q;
  logic [DATA_WIDTH-1:0] inst_opcode_q;
  logic [DATA_WIDTH-1:0] inst_op1_q;
  logic [DATA_WIDTH-1:0] inst_op2_q;
  logic [1:0]            inst_len_q;
  logic [ADDR_WIDTH-1:0] inst_pc_q;

  logic [ADDR_WIDTH-1:0] pc_inc_d;
  logic [1:0]            op_len_d;
  logic                  redirect_d;

  // NMOS 6502 instruction length. Anything not listed (implied, accumulator
  // and every undocumented opcode) is a single byte.
  function automatic logic [1:0] op_len(input logic [7:0] opc);
    logic [1:0] len;
    len = 2'd1;
    case (opc)
      8'h01, 8'h05, 8'h06, 8'h09, 8'h10, 8'h11, 8'h15, 8'h16,
      8'h21, 8'h24, 8'h25, 8'h26, 8'h29, 8'h30, 8'h31, 8'h35, 8'h36,
      8'h41, 8'h45, 8'h46, 8'h49, 8'h50, 8'h51, 8'h55, 8'h56,
      8'h61, 8'h65, 8'h66, 8'h69, 8'h70, 8'h71, 8'h75, 8'h76,
      8'h81, 8'h84, 8'h85, 8'h86, 8'h90, 8'h91, 8'h94, 8'h95, 8'h96,
      8'hA0, 8'hA1, 8'hA2, 8'hA4, 8'hA5, 8'hA6, 8'hA9,
      8'hB0, 8'hB1, 8'hB4, 8'hB5, 8'hB6,
      8'hC0, 8'hC1, 8'hC4, 8'hC5, 8'hC6, 8'hC9,
      8'hD0, 8'hD1, 8'hD5, 8'hD6,
      8'hE0, 8'hE1, 8'hE4, 8'hE5, 8'hE6, 8'hE9,
      8'hF0, 8'hF1, 8'hF5, 8'hF6:
        len = 2'd2;
      8'h0D, 8'h0E, 8'h19, 8'h1D, 8'h1E,
      8'h20, 8'h2C, 8'h2D, 8'h2E, 8'h39, 8'h3D, 8'h3E,
      8'h4C, 8'h4D, 8'h4E, 8'h59, 8'h5D, 8'h5E,
      8'h6C, 8'h6D, 8'h6E, 8'h79, 8'h7D, 8'h7E,
      8'h8C, 8'h8D, 8'h8E, 8'h99, 8'h9D,
      8'hAC, 8'hAD, 8'hAE, 8'hB9, 8'hBC, 8'hBD, 8'hBE,
      8'hCC, 8'hCD, 8'hCE, 8'hD9, 8'hDD, 8'hDE,
      8'hEC, 8'hED, 8'hEE, 8'hF9, 8'hFD, 8'hFE:
        len = 2'd3;
      default: len = 2'd1;
    endcase
    return len;
  endfunction

  // PC wraps modulo 2^ADDR_WIDTH naturally through the fixed width.
  assign pc_inc_d   = pc_q + ADDR_WIDTH'(1);
  // In B1 the opcode is on mem_rdata this very cycle, so its length decides
  // whether the first operand read is issued now.
  assign op_len_d   = op_len(mem_rdata[7:0]);
  // Redirects only apply once the vector has been loaded.
  assign redirect_d = pc_load && (state_q inside {S_OPC, S_B1, S_B2, S_B3, S_OUT});

  // Read request decode. Address is forced to zero whenever no read is issued.
  always_comb begin
    mem_rd   = 1'b0;
    mem_addr = '0;
    if (!reset) begin
      case (state_q)
        S_VLO: begin
          mem_rd   = 1'b1;
          mem_addr = RESET_VECTOR;
        end
        S_VHI: begin
          mem_rd   = 1'b1;
          mem_addr = RESET_VECTOR + ADDR_WIDTH'(1);
        end
        S_OPC: begin
          mem_rd   = 1'b1;
          mem_addr = pc_q;
        end
        S_B1: begin
          if (op_len_d != 2'd1) begin
            mem_rd   = 1'b1;
            mem_addr = pc_q;
          end
        end
        S_B2: begin
          if (inst_len_q == 2'd3) begin
            mem_rd   = 1'b1;
            mem_addr = pc_q;
          end
        end
        default: begin
          mem_rd   = 1'b0;
          mem_addr = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_VLO;
      pc_q          <= '0;
      vec_lo_q      <= '0;
      inst_valid_q  <= 1'b0;
      inst_opcode_q <= '0;
      inst_op1_q    <= '0;
      inst_op2_q    <= '0;
      inst_len_q    <= '0;
      inst_pc_q     <= '0;
    end else begin
      case (state_q)
        S_VLO: state_q <= S_VHI;
        S_VHI: begin
          vec_lo_q <= mem_rdata;
          state_q  <= S_VSET;
        end
        S_VSET: begin
          pc_q    <= {mem_rdata, vec_lo_q};
          state_q <= S_OPC;
        end
        S_OPC: begin
          pc_q    <= pc_inc_d;
          state_q <= S_B1;
        end
        S_B1: begin
          // pc_q was already advanced past the opcode in OPC.
          inst_opcode_q <= mem_rdata;
          inst_op1_q    <= '0;
          inst_op2_q    <= '0;
          inst_len_q    <= op_len_d;
          inst_pc_q     <= pc_q - ADDR_WIDTH'(1);
          if (op_len_d == 2'd1) begin
            inst_valid_q <= 1'b1;
            state_q      <= S_OUT;
          end else begin
            pc_q    <= pc_inc_d;
            state_q <= S_B2;
          end
        end
        S_B2: begin
          inst_op1_q <= mem_rdata;
          if (inst_len_q == 2'd2) begin
            inst_valid_q <= 1'b1;
            state_q      <= S_OUT;
          end else begin
            pc_q    <= pc_inc_d;
            state_q <= S_B3;
          end
        end
        S_B3: begin
          inst_op2_q   <= mem_rdata;
          inst_valid_q <= 1'b1;
          state_q      <= S_OUT;
        end
        S_OUT: begin
          if (inst_ready) begin
            inst_valid_q <= 1'b0;
            state_q      <= S_OPC;
          end
        end
        default: state_q <= S_VLO;
      endcase
      // A redirect wins over whatever the state decided above: partial bytes
      // are dropped and fetching restarts at the new PC.
      if (redirect_d) begin
        pc_q         <= pc_load_val;
        inst_valid_q <= 1'b0;
        state_q      <= S_OPC;
      end
    end
  end

  assign inst_valid  = inst_valid_q;
  assign inst_opcode = inst_opcode_q;
  assign inst_op1    = inst_op1_q;
  assign inst_op2    = inst_op2_q;
  assign inst_len    = inst_len_q;
  assign inst_pc     = inst_pc_q;
  assign pc_out      = pc_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit. A 64 KiB byte memory answers every read one
//   cycle after mem_rd. Inputs change and outputs are sampled on the falling
//   clock edge; combinational read outputs are sampled #1 after an input change.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        pc_load;
  logic [15:0] pc_load_val;
  logic        inst_valid;
  logic        inst_ready;
  logic [7:0]  inst_opcode;
  logic [7:0]  inst_op1;
  logic [7:0]  inst_op2;
  logic [1:0]  inst_len;
  logic [15:0] inst_pc;
  logic [15:0] pc_out;
  logic [2:0]  dbg_state;

  logic [7:0]  mem [0:65535];

  int n_checks;
  int n_fails;

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_rdata   (mem_rdata),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_opcode (inst_opcode),
    .inst_op1    (inst_op1),
    .inst_op2    (inst_op2),
    .inst_len    (inst_len),
    .inst_pc     (inst_pc),
    .pc_out      (pc_out),
    .dbg_state   (dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_read(input string tag, input logic rd, input logic [15:0] addr);
    chk({tag, "_rd"}, {31'd0, mem_rd}, {31'd0, rd});
    chk({tag, "_addr"}, {16'd0, mem_addr}, {16'd0, addr});
  endtask

  task automatic chk_bundle(input string tag, input logic v, input logic [7:0] opc,
                            input logic [7:0] o1, input logic [7:0] o2,
                            input logic [1:0] len, input logic [15:0] ipc);
    chk({tag, "_valid"}, {31'd0, inst_valid}, {31'd0, v});
    chk({tag, "_opcode"}, {24'd0, inst_opcode}, {24'd0, opc});
    chk({tag, "_op1"}, {24'd0, inst_op1}, {24'd0, o1});
    chk({tag, "_op2"}, {24'd0, inst_op2}, {24'd0, o2});
    chk({tag, "_len"}, {30'd0, inst_len}, {30'd0, len});
    chk({tag, "_pc"}, {16'd0, inst_pc}, {16'd0, ipc});
  endtask

  initial begin
    n_checks    = 0;
    n_fails     = 0;
    reset       = 1'b1;
    pc_load     = 1'b0;
    pc_load_val = 16'h0000;
    inst_ready  = 1'b0;
    mem_rdata   = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'hFFFC] = 8'h00;
    mem[16'hFFFD] = 8'h80;
    mem[16'h8000] = 8'hA9;
    mem[16'h8001] = 8'h42;

    // Reset state
    repeat (3) tick();
    chk_read("rst", 1'b0, 16'h0000);
    chk_bundle("rst", 1'b0, 8'h00, 8'h00, 8'h00, 2'd0, 16'h0000);
    chk("rst_pc", {16'd0, pc_out}, 32'h0000);

    // 1: vector fetch, pc_load held high to show it is ignored here
    reset       = 1'b0;
    pc_load     = 1'b1;
    pc_load_val = 16'h5555;
    #1 chk_read("vec_lo", 1'b1, 16'hFFFC);
    tick(); chk_read("vec_hi", 1'b1, 16'hFFFD);
    tick(); chk("vset_rd", {31'd0, mem_rd}, 32'd0);
    pc_load = 1'b0;
    tick(); chk("vec_pc", {16'd0, pc_out}, 32'h8000);
    chk_read("opc0", 1'b1, 16'h8000);

    // 2: two-byte LDA #$42, decoder always ready
    inst_ready = 1'b1;
    tick(); chk_read("lda_b1", 1'b1, 16'h8001);
    chk("lda_b1_valid", {31'd0, inst_valid}, 32'd0);
    tick(); chk("lda_b2_rd", {31'd0, mem_rd}, 32'd0);
    chk("lda_b2_valid", {31'd0, inst_valid}, 32'd0);
    tick(); chk_bundle("lda", 1'b1, 8'hA9, 8'h42, 8'h00, 2'd2, 16'h8000);
    chk("lda_pc", {16'd0, pc_out}, 32'h8002);
    chk("lda_out_rd", {31'd0, mem_rd}, 32'd0);
    tick(); chk("lda_done_valid", {31'd0, inst_valid}, 32'd0);
    chk_read("lda_next", 1'b1, 16'h8002);

    // 3: redirect in OPC back to 8000, three-byte JMP with a stalled decoder
    mem[16'h8000] = 8'h4C;
    mem[16'h8001] = 8'h34;
    mem[16'h8002] = 8'h12;
    inst_ready  = 1'b0;
    pc_load     = 1'b1;
    pc_load_val = 16'h8000;
    tick(); pc_load = 1'b0;
    #1 chk_read("jmp_opc", 1'b1, 16'h8000);
    chk("jmp_opc_pc", {16'd0, pc_out}, 32'h8000);
    tick(); chk_read("jmp_b1", 1'b1, 16'h8001);
    tick(); chk_read("jmp_b2", 1'b1, 16'h8002);
    tick(); chk("jmp_b3_rd", {31'd0, mem_rd}, 32'd0);
    chk("jmp_b3_valid", {31'd0, inst_valid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_bundle("jmp_hold", 1'b1, 8'h4C, 8'h34, 8'h12, 2'd3, 16'h8000);
      chk("jmp_hold_rd", {31'd0, mem_rd}, 32'd0);
      chk("jmp_hold_pc", {16'd0, pc_out}, 32'h8003);
    end
    inst_ready = 1'b1;
    tick(); chk("jmp_done_valid", {31'd0, inst_valid}, 32'd0);
    chk_read("jmp_next", 1'b1, 16'h8003);

    // 4: single-byte NOP at FFFF, PC wraps to 0000
    mem[16'hFFFF] = 8'hEA;
    pc_load     = 1'b1;
    pc_load_val = 16'hFFFF;
    tick(); pc_load = 1'b0;
    #1 chk_read("nop_opc", 1'b1, 16'hFFFF);
    tick(); chk("nop_b1_rd", {31'd0, mem_rd}, 32'd0);
    tick(); chk_bundle("nop", 1'b1, 8'hEA, 8'h00, 8'h00, 2'd1, 16'hFFFF);
    chk("nop_pc", {16'd0, pc_out}, 32'h0000);
    tick(); chk_read("nop_next", 1'b1, 16'h0000);

    // 5: redirect during B2 of LDA abs at 0000
    mem[16'h0000] = 8'hAD;
    mem[16'h0001] = 8'h11;
    mem[16'h0200] = 8'hEA;
    tick(); chk_read("abs_b1", 1'b1, 16'h0001);
    tick(); chk_read("abs_b2", 1'b1, 16'h0002);
    pc_load     = 1'b1;
    pc_load_val = 16'h0200;
    tick(); pc_load = 1'b0;
    #1 chk("redir_valid", {31'd0, inst_valid}, 32'd0);
    chk_read("redir", 1'b1, 16'h0200);
    chk("redir_pc", {16'd0, pc_out}, 32'h0200);
    tick(); chk("redir_b1_valid", {31'd0, inst_valid}, 32'd0);
    tick(); chk_bundle("redir_nop", 1'b1, 8'hEA, 8'h00, 8'h00, 2'd1, 16'h0200);

    // Handshake and redirect in the same OUT cycle
    pc_load     = 1'b1;
    pc_load_val = 16'h0300;
    tick(); pc_load = 1'b0;
    #1 chk("hs_redir_valid", {31'd0, inst_valid}, 32'd0);
    chk_read("hs_redir", 1'b1, 16'h0300);

    // 6: reset in B1, new vector 1234
    mem[16'h0300] = 8'hA9;
    mem[16'hFFFC] = 8'h34;
    mem[16'hFFFD] = 8'h12;
    tick(); reset = 1'b1;
    #1 chk_read("rst_b1", 1'b0, 16'h0000);
    tick(); chk_bundle("rst_b1", 1'b0, 8'h00, 8'h00, 8'h00, 2'd0, 16'h0000);
    chk("rst_b1_pc", {16'd0, pc_out}, 32'h0000);
    reset = 1'b0;
    #1 chk_read("rv_lo", 1'b1, 16'hFFFC);
    tick(); chk_read("rv_hi", 1'b1, 16'hFFFD);
    tick(); chk("rv_set_rd", {31'd0, mem_rd}, 32'd0);
    tick(); chk("rv_pc", {16'd0, pc_out}, 32'h1234);
    chk_read("rv_opc", 1'b1, 16'h1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
